clock_set_ctrl: RTL
===================

// Module: clock_set_ctrl
// PURPOSE
// Mode/sequencing controller for the digital clock's three bcd counter chains (sec N=60, min N=60, hr N=24).
// - Generates the 1 Hz seconds tick and routes carries sec->min->hr in RUN.
// - In SET_HR / SET_MIN: freezes seconds, steps the selected counter from the inc button, drives display blink.
// - Sits between debounced buttons and the counter instances; the counters themselves are unchanged.
// PARAMETERS
// TICK_DIV    100_000_000  clk cycles per seconds tick (>=2)
// BLINK_DIV   25_000_000   clk cycles per blink toggle (>=1)
// HOLD_CYC    50_000_000   cycles btn_inc held before auto-repeat starts (>=1)
// REPEAT_CYC  20_000_000   cycles between auto-repeat pulses (>=1)
// PORTS
// clk        in   1  system clock
// reset      in   1  asynchronous reset, active-high
// btn_mode   in   1  debounced single-cycle pulse: advance mode
// btn_inc    in   1  debounced level: increment request (held = auto-repeat)
// sec_cout   in   1  seconds counter carry (combinational, asserted with sec_cin at count 59)
// min_cout   in   1  minutes counter carry (same rule, at count 59)
// sec_cin    out  1  seconds counter enable pulse
// min_cin    out  1  minutes counter enable pulse
// hr_cin     out  1  hours counter enable pulse
// mode       out  2  00=RUN, 01=SET_HR, 10=SET_MIN (11 unused)
// blank_hr   out  1  blank hour digits (blink phase)
// blank_min  out  1  blank minute digits (blink phase)
// BEHAVIOUR
// - Reset: state=RUN, prescaler=0, blink=0, hold/repeat counters=0, inc edge reg=0.
//   All outputs 0 during reset (mode=00).
// - FSM (registered) advances on btn_mode only: RUN->SET_HR->SET_MIN->RUN. mode output = state encoding.
// - Prescaler (width $clog2(TICK_DIV)) counts 0..TICK_DIV-1 and wraps, in RUN only.
//   Held at 0 in both SET states, so the first tick after returning to RUN is exactly TICK_DIV cycles later.
// - sec_cin = (state==RUN) && (prescaler==TICK_DIV-1); combinational, 1 cycle wide. Never asserted in SET states.
// - RUN: min_cin = sec_cout; hr_cin = min_cout (combinational pass-through, same cycle).
// - SET_HR: hr_cin = inc_pulse; min_cin = 0.
// - SET_MIN: min_cin = inc_pulse; hr_cin = 0. A min_cout produced at 59->00 is NOT propagated to hours.
// - inc_pulse (registered, 1 cycle):
//   - fires in the cycle after btn_inc's rising edge is seen;
//   - after btn_inc stays high HOLD_CYC further cycles, fires once, then every REPEAT_CYC cycles while held;
//   - release clears hold/repeat counters;
//   - suppressed (and counters cleared) in RUN.
// - btn_mode and an inc_pulse in the same cycle: mode change wins, inc_pulse dropped, hold/repeat counters cleared.
//   A still-held btn_inc does not re-fire until released and pressed again.
// - Blink: toggle reg flips every BLINK_DIV cycles in SET states, forced 0 in RUN.
//   blank_hr = (state==SET_HR)&blink; blank_min = (state==SET_MIN)&blink.
//   Blink counter restarts at 0 on every mode change, so each field starts visible.
// - Reset mid-operation (any state/counter value): immediate return to reset values; no spurious cin pulse.
// - No output ever pulses for more than 1 consecutive cycle except blank_* and mode.
// TESTING (TICK_DIV=10, BLINK_DIV=4, HOLD_CYC=20, REPEAT_CYC=5)
// 1 Release reset, RUN, no buttons -> sec_cin high on cycles 10,20,30..., exactly 1 cycle each; min_cin/hr_cin follow sec_cout/min_cout in the same cycle.
// 2 btn_mode pulse x1 -> mode=01; sec_cin stays 0 for 100 cycles; blank_hr toggles every 4 cycles starting 0; blank_min=0.
// 3 In SET_MIN, btn_inc high 1 cycle -> exactly one min_cin 1 cycle after the edge; forced min_cout=1 then -> hr_cin stays 0.
// 4 In SET_HR, btn_inc held 40 cycles -> hr_cin at t+1, then t+21, t+26, t+31, t+36; none after release.
// 5 btn_mode pulse same cycle as inc edge in SET_MIN -> mode=00, no min_cin; first sec_cin exactly 10 cycles later.
// 6 Assert reset mid-count in SET_HR with btn_inc held -> all outputs 0 immediately; after release, RUN resumes with sec_cin at cycle 10.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
// Mode and sequencing controller for a digital clock built from three BCD
// counter chains (seconds mod 60, minutes mod 60, hours mod 24).
//   RUN     : generates the seconds tick from a prescaler and passes the
//             sec->min and min->hr carries straight through.
//   SET_HR  : seconds frozen, hours stepped from btn_inc, hour digits blink.
//   SET_MIN : seconds frozen, minutes stepped from btn_inc, minute digits
//             blink; a minute wrap is not propagated to the hours.
// btn_inc gives one step on press, then auto-repeats while held.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous reset, active-high
//   btn_mode   in   debounced one-cycle pulse, advances the mode
//   btn_inc    in   debounced level, increment request
//   sec_cout   in   seconds counter carry (combinational)
//   min_cout   in   minutes counter carry (combinational)
//   sec_cin    out  seconds counter enable pulse
//   min_cin    out  minutes counter enable pulse
//   hr_cin     out  hours counter enable pulse
//   mode[1:0]  out  00=RUN, 01=SET_HR, 10=SET_MIN
//   blank_hr   out  blank the hour digits (blink phase)
//   blank_min  out  blank the minute digits (blink phase)
module clock_set_ctrl #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 20_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       sec_cout,
  input  logic       min_cout,
  output logic       sec_cin,
  output logic       min_cin,
  output logic       hr_cin,
  output logic [1:0] mode,
  output logic       blank_hr,
  output logic       blank_min
);

  localparam int PW   = $clog2(TICK_DIV);
  localparam int BW   = $clog2(BLINK_DIV + 1);
  localparam int CMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST  = BW'(BLINK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   presc;
  logic [BW-1:0]   bcnt;
  logic            blink;
  logic            inc_d;
  logic            inc_lock;
  logic            inc_rep;
  logic [CW-1:0]   hcnt;
  logic            inc_pulse;
  logic            inc_fire;

  // Mode state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (btn_mode) begin
      case (state)
        RUN:     state_nxt = SET_HR;
        SET_HR:  state_nxt = SET_MIN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // Seconds prescaler: only runs in RUN and restarts from 0 on any mode
  // change, so re-entering RUN gives a full TICK_DIV period to the first tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (state != RUN || btn_mode) begin
      presc <= '0;
    end else if (presc == PRE_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Blink phase: restarts visible on every mode change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt  <= '0;
      blink <= 1'b0;
    end else if (state == RUN || btn_mode) begin
      bcnt  <= '0;
      blink <= 1'b0;
    end else if (bcnt == BLK_LAST) begin
      bcnt  <= '0;
      blink <= ~blink;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  // Increment button: pulse on press, then after HOLD_CYC held cycles and
  // every REPEAT_CYC cycles after that. hcnt counts held cycles since the
  // last pulse; inc_rep selects which interval is being timed.
  // inc_lock keeps a button that was held through a mode change silent
  // until it is released and pressed again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inc_d     <= 1'b0;
      inc_lock  <= 1'b0;
      inc_rep   <= 1'b0;
      hcnt      <= '0;
      inc_pulse <= 1'b0;
    end else begin
      inc_d     <= btn_inc;
      inc_pulse <= 1'b0;
      if (state == RUN || btn_mode) begin
        inc_lock <= btn_mode & btn_inc;
        inc_rep  <= 1'b0;
        hcnt     <= '0;
      end else if (!btn_inc || inc_lock) begin
        inc_lock <= inc_lock & btn_inc;
        inc_rep  <= 1'b0;
        hcnt     <= '0;
      end else if (!inc_d) begin
        inc_pulse <= 1'b1;
        inc_rep   <= 1'b0;
        hcnt      <= CW'(1);
      end else if (hcnt == (inc_rep ? REP_LAST : HOLD_LAST)) begin
        inc_pulse <= 1'b1;
        inc_rep   <= 1'b1;
        hcnt      <= CW'(1);
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // A mode change in the same cycle as a registered pulse drops the pulse
  assign inc_fire = inc_pulse & ~btn_mode;

  // Counter enables and display blanking. Everything is forced low while
  // reset is asserted so that carry inputs cannot leak through.
  always_comb begin
    sec_cin   = 1'b0;
    min_cin   = 1'b0;
    hr_cin    = 1'b0;
    blank_hr  = 1'b0;
    blank_min = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          sec_cin = (presc == PRE_LAST);
          min_cin = sec_cout;
          hr_cin  = min_cout;
        end
        SET_HR: begin
          hr_cin   = inc_fire;
          blank_hr = blink;
        end
        SET_MIN: begin
          min_cin   = inc_fire;
          blank_min = blink;
        end
        default: begin
        end
      endcase
    end
  end

  assign mode = state;

endmodule
